// File: rtl/deskew_writeback.sv
// Staircase de-skew, aligned-row FIFO and valid/ready writeback with address generation.
// Optional macro DESKEW_ROW_CHECK_EN adds the sticky partial-row detector on skew_err.
module deskew_writeback #(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_start,
    input  logic [ADDR_WIDTH-1:0]               cfg_base_addr,
    input  logic [ADDR_WIDTH:0]                 cfg_num_rows,
    input  logic [LANES-1:0]                    cfg_lane_mask,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    in_data,
    input  logic [LANES-1:0]                    in_valid,
    output logic                                wr_valid,
    input  logic                                wr_ready,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    wr_data,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow,
    output logic                                skew_err
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // state   | meaning
    // S_IDLE  | waiting for cfg_start, aligned rows dropped silently
    // S_RUN   | collecting rows until rows_in reaches the job length
    // S_FLUSH | draining the FIFO, late rows flagged as overflow
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic [ADDR_WIDTH-1:0]               base_q;
    logic [ADDR_WIDTH:0]                 num_q;
    logic [LANES-1:0]                    mask_q;
    logic [ADDR_WIDTH:0]                 rows_in_q, rows_in_d;
    logic [ADDR_WIDTH-1:0]               rows_out_q;
    logic                                ovf_q;
    logic [LANES-1:0][DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]                       wptr_q, rptr_q;
    logic [PW:0]                         cnt_q, cnt_d;

    logic [LANES-1:0]                    dly_v;
    logic [LANES-1:0][DATA_WIDTH-1:0]    dly_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]    row_masked;
    logic                                row_hit, row_all, row_aligned;
    logic                                push, pop, set_ovf, fifo_full, start_acc;
    logic [LANES-1:0]                    mask_eff;

    // Lane j is delayed by LANES-1-j stages so every lane of a row lines up with lane LANES-1.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int D = LANES - 1 - j;
        if (D == 0) begin : g_pass
            assign dly_v[j] = in_valid[j];
            assign dly_d[j] = in_data[j];
        end else begin : g_pipe
            logic [D-1:0]                 v_q;
            logic [D-1:0][DATA_WIDTH-1:0] d_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    d_q <= '0;
                end else begin
                    v_q[0] <= in_valid[j];
                    d_q[0] <= in_data[j];
                    for (int k = 1; k < D; k++) begin
                        v_q[k] <= v_q[k-1];
                        d_q[k] <= d_q[k-1];
                    end
                end
            end
            assign dly_v[j] = v_q[D-1];
            assign dly_d[j] = d_q[D-1];
        end
    end

    assign row_hit     = |(dly_v & mask_q);
    assign row_all     = &(dly_v | ~mask_q);
    assign row_aligned = row_hit & row_all;

    always_comb begin
        row_masked = '0;
        for (int j = 0; j < LANES; j++) begin
            row_masked[j] = mask_q[j] ? dly_d[j] : '0;
        end
    end

    assign mask_eff  = (cfg_lane_mask == '0) ? '1 : cfg_lane_mask;
    assign start_acc = cfg_start && (state_q == S_IDLE);
    assign fifo_full = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign wr_valid  = (cnt_q != '0);
    assign pop       = wr_valid && wr_ready;

    always_comb begin
        state_d   = state_q;
        rows_in_d = rows_in_q;
        push      = 1'b0;
        set_ovf   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    rows_in_d = '0;
                    state_d   = (cfg_num_rows == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (row_aligned) begin
                    rows_in_d = rows_in_q + 1'b1;
                    // A full FIFO still accepts the row when a pop frees a slot this cycle.
                    if (!fifo_full || pop) push    = 1'b1;
                    else                   set_ovf = 1'b1;
                    if (rows_in_d == num_q) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (row_aligned) set_ovf = 1'b1;
                if ((cnt_q == '0) || ((cnt_q == (PW+1)'(1)) && pop)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            mask_q     <= '0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            ovf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rows_in_q <= rows_in_d;
            cnt_q     <= cnt_d;
            if (start_acc) begin
                base_q     <= cfg_base_addr;
                num_q      <= cfg_num_rows;
                mask_q     <= mask_eff;
                rows_out_q <= '0;
                ovf_q      <= 1'b0;
            end else begin
                if (pop)     rows_out_q <= rows_out_q + 1'b1;
                if (set_ovf) ovf_q      <= 1'b1;
            end
            if (push) begin
                mem_q[wptr_q] <= row_masked;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

`ifdef DESKEW_ROW_CHECK_EN
    logic skew_q;
    logic partial;
    assign partial = row_hit & ~row_all;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         skew_q <= 1'b0;
        else if (start_acc) skew_q <= 1'b0;
        else if (partial)   skew_q <= 1'b1;
    end
    assign skew_err = skew_q;
`else
    assign skew_err = 1'b0;
`endif

    assign wr_addr  = base_q + rows_out_q;
    assign wr_data  = mem_q[rptr_q];
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_deskew_writeback.sv
// Scoreboard bench for deskew_writeback with LANES=4: expected rows are queued as
// staircase stimulus is driven and compared as the DUT hands rows to the output buffer.
module tb_deskew_writeback;

    localparam int L  = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int FD = 4;
`ifdef DESKEW_ROW_CHECK_EN
    localparam logic EXP_SKEW = 1'b1;
`else
    localparam logic EXP_SKEW = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_start = 1'b0;
    logic [AW-1:0]          cfg_base_addr = '0;
    logic [AW:0]            cfg_num_rows = '0;
    logic [L-1:0]           cfg_lane_mask = '0;
    logic [L-1:0][DW-1:0]   in_data = '0;
    logic [L-1:0]           in_valid = '0;
    logic                   wr_valid;
    logic                   rdy = 1'b1;
    logic [AW-1:0]          wr_addr;
    logic [L-1:0][DW-1:0]   wr_data;
    logic                   busy, done, overflow, skew_err;

    deskew_writeback #(.LANES(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_rows(cfg_num_rows), .cfg_lane_mask(cfg_lane_mask), .in_data(in_data),
        .in_valid(in_valid), .wr_valid(wr_valid), .wr_ready(rdy), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int last_xfer_cyc = 0;
    int start_cyc = 0;
    logic [AW-1:0]   exp_addr_q [$];
    logic [L*DW-1:0] exp_data_q [$];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    logic            pv = 1'b0, pr = 1'b0;
    logic [AW-1:0]   pa = '0;
    logic [L*DW-1:0] pd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check_val("hold_valid", wr_valid, 1);
                check_val("hold_addr", wr_addr, pa);
                check_val("hold_data", wr_data, pd);
            end
            if (wr_valid && rdy) begin
                xfer_cnt++;
                last_xfer_cyc = cyc;
                check_val("sb_has_entry", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) begin
                    check_val("wr_addr", wr_addr, exp_addr_q.pop_front());
                    check_val("wr_data", wr_data, exp_data_q.pop_front());
                end
            end
            pv = wr_valid;
            pr = rdy;
            pa = wr_addr;
            pd = wr_data;
        end
    end

    function automatic logic [DW-1:0] lane_val(input int job, input int r, input int j);
        return {8'hC5, 8'(job), 8'(r), 8'(j + 1)};
    endfunction

    task automatic start_job(input logic [AW-1:0] base, input logic [AW:0] rows, input logic [L-1:0] mask);
        cfg_base_addr = base;
        cfg_num_rows  = rows;
        cfg_lane_mask = mask;
        cfg_start     = 1'b1;
        start_cyc     = cyc;
        @(posedge clk);
        #1 cfg_start = 1'b0;
    endtask

    // Lane j carries row c-j in cycle c; rows listed as kept are queued with consecutive addresses.
    task automatic send_rows(input int job, input int n, input logic [L-1:0] drv_mask,
                             input logic [L-1:0] cfg_mask, input logic [AW-1:0] base,
                             input int hold_row, input int hold_lane, input int keep);
        logic [L-1:0]    eff;
        logic [L*DW-1:0] row;
        int k;
        int r;
        int rd;
        eff = (cfg_mask == '0) ? '1 : cfg_mask;
        k = 0;
        for (int c = 0; c < n + L - 1; c++) begin
            for (int j = 0; j < L; j++) begin
                r = c - j;
                if (r >= 0 && r < n) begin
                    in_data[j]  = lane_val(job, r, j);
                    in_valid[j] = drv_mask[j] && !(r == hold_row && j == hold_lane);
                end else begin
                    in_data[j]  = '0;
                    in_valid[j] = 1'b0;
                end
            end
            rd = c - (L - 1);
            if (rd >= 0 && rd != hold_row && k < keep) begin
                for (int j = 0; j < L; j++)
                    row[j*DW +: DW] = eff[j] ? lane_val(job, rd, j) : '0;
                exp_addr_q.push_back(AW'(int'(base) + k));
                exp_data_q.push_back(row);
                k++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        int seen;
        seen = 0;
        dcyc = -1;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                dcyc = cyc;
            end
        end
        check_val({tag, "_done_seen"}, seen, 1);
        if (seen != 0) begin
            @(negedge clk);
            check_val({tag, "_done_1cyc"}, done, 0);
            check_val({tag, "_idle"}, busy, 0);
        end
        check_val({tag, "_sb_empty"}, exp_addr_q.size(), 0);
    endtask

    initial begin
        int d;
        int x0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_wr_valid", wr_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_skew", skew_err, 0);
        check_val("rst_wr_data", wr_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // basic three-row job
        x0 = xfer_cnt;
        start_job(10'd10, 11'd3, 4'hF);
        check_val("basic_busy", busy, 1);
        send_rows(1, 3, 4'hF, 4'hF, 10'd10, -1, 0, 3);
        wait_done("basic", d);
        check_val("basic_done_lat", d, last_xfer_cyc + 1);
        check_val("basic_xfers", xfer_cnt - x0, 3);
        check_val("basic_ovf", overflow, 0);
        check_val("basic_skew", skew_err, 0);

        // lane mask, then all-zero mask treated as all lanes
        start_job(10'd0, 11'd2, 4'b0011);
        send_rows(2, 2, 4'b0011, 4'b0011, 10'd0, -1, 0, 2);
        wait_done("mask3", d);
        start_job(10'd20, 11'd2, 4'b0000);
        send_rows(3, 2, 4'hF, 4'b0000, 10'd20, -1, 0, 2);
        wait_done("mask0", d);

        // backpressure: FIFO fills, the last two rows are dropped
        rdy = 1'b0;
        x0 = xfer_cnt;
        start_job(10'd100, 11'd6, 4'hF);
        send_rows(4, 6, 4'hF, 4'hF, 10'd100, -1, 0, 4);
        @(negedge clk);
        check_val("bp_ovf_mid", overflow, 1);
        check_val("bp_wr_valid", wr_valid, 1);
        @(posedge clk);
        #1 rdy = 1'b1;
        wait_done("bp", d);
        check_val("bp_xfers", xfer_cnt - x0, 4);
        check_val("bp_ovf_end", overflow, 1);

        // address wrap, overflow cleared by the new start
        start_job(10'd1022, 11'd4, 4'hF);
        #1 check_val("wrap_ovf_clr", overflow, 0);
        send_rows(5, 4, 4'hF, 4'hF, 10'd1022, -1, 0, 4);
        wait_done("wrap", d);

        // zero-row job
        x0 = xfer_cnt;
        start_job(10'd5, 11'd0, 4'hF);
        wait_done("zero", d);
        check_val("zero_done_lat", d, start_cyc + 1);
        check_val("zero_xfers", xfer_cnt - x0, 0);

        // partial row: lane 2 withheld in row 1
        start_job(10'd200, 11'd3, 4'hF);
        send_rows(6, 4, 4'hF, 4'hF, 10'd200, 1, 2, 3);
        wait_done("skew", d);
        check_val("skew_flag", skew_err, EXP_SKEW);
        check_val("skew_ovf", overflow, 0);

        // reset in the middle of a job with two rows queued and overflow set
        rdy = 1'b0;
        start_job(10'd300, 11'd2, 4'hF);
        send_rows(7, 3, 4'hF, 4'hF, 10'd300, -1, 0, 2);
        @(negedge clk);
        check_val("mid_wr_valid", wr_valid, 1);
        check_val("mid_busy", busy, 1);
        check_val("mid_ovf", overflow, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("mrst_wr_valid", wr_valid, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_ovf", overflow, 0);
        check_val("mrst_wr_data", wr_data, 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy = 1'b1;
        @(posedge clk);
        #1;

        // clean job after reset
        x0 = xfer_cnt;
        start_job(10'd10, 11'd3, 4'hF);
        send_rows(8, 3, 4'hF, 4'hF, 10'd10, -1, 0, 3);
        wait_done("post", d);
        check_val("post_xfers", xfer_cnt - x0, 3);
        check_val("post_ovf", overflow, 0);
        check_val("post_skew", skew_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

endmodule
